operand_select_pipe: RTL

- Parametrised, pipelined successor to the datapath operand multiplexer.
- Selects one operand per accepted request from a bank of NREGS registers, an R-type operand input, or a sign/zero-extended immediate.
- Adds writeback bypass, a valid/ready handshake and a one-entry skid buffer.
- Sits between register-file read and the ALU input stage; one operand per instance (two instances per datapath).

---
 rtl/operand_select_pipe_if.sv | 33 +++
 rtl/operand_select_pipe.sv | 124 ++++++++++++
 2 files changed

// File: rtl/operand_select_pipe_if.sv
// Request/operand bundle for operand_select_pipe: selection inputs plus valid/ready handshakes.
// slave is the pipe's view; master is the producer/consumer side that drives requests and drains operands.
interface operand_select_pipe_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned SEL_W = 5,
  parameter int unsigned IMM_W = 8
) ();
  logic [NREGS*WIDTH-1:0] regs_in;
  logic [WIDTH-1:0]       reg_r;
  logic [IMM_W-1:0]       imm;
  logic [SEL_W-1:0]       sel;
  logic [1:0]             mode;
  logic                   wb_en;
  logic [SEL_W-1:0]       wb_idx;
  logic [WIDTH-1:0]       wb_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_bypassed;

  modport master (
    output regs_in, reg_r, imm, sel, mode, wb_en, wb_idx, wb_data, in_valid, out_ready,
    input  in_ready, out_valid, out_data, out_bypassed
  );

  modport slave (
    input  regs_in, reg_r, imm, sel, mode, wb_en, wb_idx, wb_data, in_valid, out_ready,
    output in_ready, out_valid, out_data, out_bypassed
  );
endinterface

// File: rtl/operand_select_pipe.sv
// Pipelined operand multiplexer: register/bypass/R-type/immediate select into a 1-cycle output
// register backed by a one-entry skid buffer so in_ready never depends combinationally on out_ready.
module operand_select_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned SEL_W = 5,
  parameter int unsigned IMM_W = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  operand_select_pipe_if.slave bus
);

  localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  // State bits are {skid_valid, out_valid} so both handshake outputs come straight from flops.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] out_data_q;
  logic             out_byp_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             skid_byp_q;
  logic [WIDTH-1:0] sel_data_c;
  logic             sel_byp_c;
  logic             accept_c;
  logic             load_out_in_c;
  logic             load_out_skid_c;
  logic             load_skid_c;
  logic [WIDTH-1:0] regs [NREGS];

  for (genvar k = 0; k < NREGS; k++) begin : g_unpack
    assign regs[k] = bus.regs_in[k*WIDTH +: WIDTH];
  end

  // Operand source select; codes at or above NREGS fall through to the mode-selected source.
  always_comb begin
    sel_data_c = '0;
    sel_byp_c  = 1'b0;
    if (32'(bus.sel) < NREGS) begin
      if (bus.wb_en && (bus.wb_idx == bus.sel)) begin
        sel_data_c = bus.wb_data;
        sel_byp_c  = 1'b1;
      end else begin
        sel_data_c = regs[bus.sel[IDX_W-1:0]];
      end
    end else begin
      case (bus.mode)
        2'd0:    sel_data_c = bus.reg_r;
        2'd1:    sel_data_c = WIDTH'($signed(bus.imm));
        2'd2:    sel_data_c = WIDTH'(bus.imm);
        default: sel_data_c = '0;
      endcase
    end
  end

  // Occupancy FSM and datapath load enables.
  always_comb begin
    state_nxt       = state;
    load_out_in_c   = 1'b0;
    load_out_skid_c = 1'b0;
    load_skid_c     = 1'b0;
    accept_c        = bus.in_valid && !state[1];
    case (state)
      ST_EMPTY: begin
        if (accept_c) begin
          load_out_in_c = 1'b1;
          state_nxt     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (bus.out_ready) begin
          if (accept_c) load_out_in_c = 1'b1;
          else          state_nxt     = ST_EMPTY;
        end else if (accept_c) begin
          load_skid_c = 1'b1;
          state_nxt   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (bus.out_ready) begin
          load_out_skid_c = 1'b1;
          state_nxt       = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_EMPTY;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_byp_q   <= 1'b0;
      skid_data_q <= '0;
      skid_byp_q  <= 1'b0;
    end else begin
      if (load_out_in_c) begin
        out_data_q <= sel_data_c;
        out_byp_q  <= sel_byp_c;
      end else if (load_out_skid_c) begin
        out_data_q <= skid_data_q;
        out_byp_q  <= skid_byp_q;
      end
      if (load_skid_c) begin
        skid_data_q <= sel_data_c;
        skid_byp_q  <= sel_byp_c;
      end
    end
  end

  assign bus.out_valid    = state[0];
  assign bus.in_ready     = ~state[1];
  assign bus.out_data     = out_data_q;
  assign bus.out_bypassed = out_byp_q;

endmodule
